// File: rtl/ripple_accum_4bit_pkg.sv
// Shared definitions for the burst accumulator: FSM encodings and default sizing.
package ripple_accum_4bit_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_N_OPS = 4;
  localparam int DEF_CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/ripple_4bit.sv
// Ripple-carry adder: o_sum/o_cout = i_a + i_b + i_cin, one full-adder cell per bit.
module ripple_4bit #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout
);

  logic [WIDTH:0] w_carry;

  assign w_carry[0] = i_cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign o_sum[i]       = i_a[i] ^ i_b[i] ^ w_carry[i];
    assign w_carry[i + 1] = (i_a[i] & i_b[i]) | (w_carry[i] & (i_a[i] ^ i_b[i]));
  end

  assign o_cout = w_carry[WIDTH];

endmodule

// File: rtl/ripple_accum_4bit.sv
// Accumulates a burst of N_OPS operands via a ripple adder and hands the result to a sink.
// Define ACC_SATURATE_EN to clamp the accumulator at all-ones on overflow instead of wrapping.
module ripple_accum_4bit
  import ripple_accum_4bit_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int N_OPS = DEF_N_OPS,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] din,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic [CNT_W-1:0] op_count
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry_out;
  logic [CNT_W-1:0] r_op_count;

  logic             w_fire;
  logic             w_last;
  logic             w_cin;
  logic [WIDTH-1:0] w_add_sum;
  logic             w_add_cout;
  logic [WIDTH-1:0] w_acc_nxt;

  assign w_fire = in_valid & in_ready;
  assign w_last = (r_op_count == CNT_W'(N_OPS - 1));
  assign w_cin  = (r_op_count == '0) ? cin : 1'b0;

  ripple_4bit #(
    .WIDTH (WIDTH)
  ) u_adder (
    .i_a    (r_acc),
    .i_b    (din),
    .i_cin  (w_cin),
    .o_sum  (w_add_sum),
    .o_cout (w_add_cout)
  );

`ifdef ACC_SATURATE_EN
  // The sticky carry flag doubles as "already saturated in this burst".
  assign w_acc_nxt = (w_add_cout || r_carry_out) ? {WIDTH{1'b1}} : w_add_sum;
`else
  assign w_acc_nxt = w_add_sum;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_acc       <= '0;
      r_sum       <= '0;
      r_carry_out <= 1'b0;
      r_op_count  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_IDLE) begin
        r_acc       <= '0;
        r_carry_out <= 1'b0;
        r_op_count  <= '0;
      end else if (w_fire) begin
        r_acc       <= w_acc_nxt;
        r_carry_out <= r_carry_out | w_add_cout;
        r_op_count  <= r_op_count + 1'b1;
        if (w_last) begin
          r_sum <= w_acc_nxt;
        end
      end
    end
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  w_state_nxt = ST_ACCUM;
      ST_ACCUM: if (w_fire && w_last) w_state_nxt = ST_DONE;
      ST_DONE:  if (out_ready) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      ST_ACCUM: in_ready  = 1'b1;
      ST_DONE:  out_valid = 1'b1;
      default:  ;
    endcase
  end

  assign sum       = r_sum;
  assign carry_out = r_carry_out;
  assign op_count  = r_op_count;

endmodule

// File: tb/tb_ripple_accum_4bit.sv
// Scoreboard bench for ripple_accum_4bit: directed bursts push expected results, a monitor pops on output handshake.
module tb_ripple_accum_4bit;

  typedef struct packed {
    logic [3:0] sum;
    logic       carry;
  } exp_t;

`ifdef ACC_SATURATE_EN
  localparam logic [3:0] EXP3_SUM = 4'd15;
  localparam logic [3:0] EXP4_SUM = 4'd15;
`else
  localparam logic [3:0] EXP3_SUM = 4'd10;
  localparam logic [3:0] EXP4_SUM = 4'd4;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] din = 4'd0;
  logic       cin = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [3:0] sum;
  logic       carry_out;
  logic [3:0] op_count;

  int   tests = 0;
  int   fails = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  ripple_accum_4bit dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din       (din),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry_out (carry_out),
    .op_count  (op_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one operand at a negedge, hold it until in_ready, let the next posedge take it.
  task automatic send(input logic [3:0] d, input logic c);
    int n;
    @(negedge clk);
    in_valid = 1'b1;
    din      = d;
    cin      = c;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("send_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic burst(input logic [3:0] d0, input logic [3:0] d1, input logic [3:0] d2,
                       input logic [3:0] d3, input logic c, input logic [3:0] es,
                       input logic ec);
    exp_t e;
    e.sum   = es;
    e.carry = ec;
    sb_q.push_back(e);
    send(d0, c);
    send(d1, c);
    send(d2, c);
    send(d3, c);
    @(negedge clk);
    check("latency_out_valid", {31'd0, out_valid}, 32'd1);
    check("latency_in_ready", {31'd0, in_ready}, 32'd0);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("drain", sb_q.size(), 32'd0);
  endtask

  // Monitor: compares each accepted result against the oldest expected entry.
  always @(negedge clk) begin
    exp_t e;
    if (out_valid) check("excl_ready_valid", {31'd0, in_ready}, 32'd0);
    if (out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_result: got sum %0d with empty scoreboard at %0t", sum, $time);
      end else begin
        e = sb_q.pop_front();
        check("result_sum", {28'd0, sum}, {28'd0, e.sum});
        check("result_carry", {31'd0, carry_out}, {31'd0, e.carry});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1);
  end

  initial begin
    logic [3:0] t5_vals[4];
    logic [3:0] t5_junk[4];
    exp_t       e5;
    t5_vals = '{4'd1, 4'd2, 4'd3, 4'd4};
    t5_junk = '{4'd9, 4'd7, 4'd8, 4'd6};

    // 1: reset state and first IDLE cycle
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_sum", {28'd0, sum}, 32'd0);
    check("rst_carry", {31'd0, carry_out}, 32'd0);
    check("rst_op_count", {28'd0, op_count}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    check("accum_in_ready", {31'd0, in_ready}, 32'd1);

    // 2: plain burst, no carry
    burst(4'd1, 4'd2, 4'd3, 4'd4, 1'b0, 4'd10, 1'b0);
    wait_drain();

    // 3: cin on first operand, overflow
    burst(4'd8, 4'd9, 4'd1, 4'd7, 1'b1, EXP3_SUM, 1'b1);
    wait_drain();

    // 4: sink back-pressure in DONE
    out_ready = 1'b0;
    burst(4'd5, 4'd5, 4'd5, 4'd5, 1'b0, EXP4_SUM, 1'b1);
    repeat (5) begin
      @(negedge clk);
      check("stall_out_valid", {31'd0, out_valid}, 32'd1);
      check("stall_in_ready", {31'd0, in_ready}, 32'd0);
      check("stall_sum", {28'd0, sum}, {28'd0, EXP4_SUM});
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("post_done_idle_in_ready", {31'd0, in_ready}, 32'd0);
    check("post_done_idle_out_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    check("post_done_accum_in_ready", {31'd0, in_ready}, 32'd1);
    wait_drain();

    // 5: gapped in_valid; only accepted beats count
    e5.sum   = 4'd10;
    e5.carry = 1'b0;
    sb_q.push_back(e5);
    for (int i = 0; i < 4; i++) begin
      send(t5_vals[i], 1'b0);
      @(negedge clk);
      check("gap_op_count", {28'd0, op_count}, i + 1);
      if (i < 3) begin
        din = t5_junk[i];
        @(negedge clk);
        check("gap_op_count_hold", {28'd0, op_count}, i + 1);
      end
    end
    wait_drain();

    // 6: reset aborts a partial burst
    send(4'd1, 1'b0);
    send(4'd5, 1'b0);
    @(negedge clk);
    check("partial_op_count", {28'd0, op_count}, 32'd2);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_op_count", {28'd0, op_count}, 32'd0);
    check("abort_sum", {28'd0, sum}, 32'd0);
    check("abort_carry", {31'd0, carry_out}, 32'd0);
    check("abort_in_ready", {31'd0, in_ready}, 32'd0);
    check("abort_out_valid", {31'd0, out_valid}, 32'd0);
    burst(4'd1, 4'd1, 4'd1, 4'd1, 1'b0, 4'd4, 1'b0);
    wait_drain();

    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
